// File: rtl/apb_master_ctrl.sv
// APB4 master: single-outstanding command port to SETUP/ACCESS transfers,
// with address-decoded slave select and a stall timeout.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             Pclk,
  input  logic                             Presetn,
  input  logic                             transfer,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            Paddr,
  output logic [NUM_SLAVES-1:0]            Psel,
  output logic                             Penable,
  output logic                             Pwrite,
  output logic [DATA_WIDTH-1:0]            Pwdata,
  output logic [DATA_WIDTH/8-1:0]          Pstrb,
  input  logic [NUM_SLAVES-1:0]            Pready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Prdata,
  input  logic [NUM_SLAVES-1:0]            Pslverr
);

  localparam int SB = $clog2(NUM_SLAVES);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [SB-1:0]         cmd_idx;
  logic [SB:0]           idx_ext;
  logic                  dec_err;
  logic [SB-1:0]         idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         strb_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  to_q;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  to_hit;

  assign cmd_idx = cmd_addr[ADDR_WIDTH-1 -: SB];
  assign idx_ext = {1'b0, cmd_idx};
  assign dec_err = idx_ext >= (SB+1)'(NUM_SLAVES);
  assign to_hit  = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  // Only the addressed slave's response lines are ever looked at
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    Psel      = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == SB'(i)) begin
        sel_ready = Pready[i];
        sel_err   = Pslverr[i];
        sel_rdata = Prdata[i*DATA_WIDTH +: DATA_WIDTH];
        Psel[i]   = (state == SETUP) || (state == ACCESS);
      end
    end
  end

  always_ff @(posedge Pclk) begin
    if (!Presetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (transfer) state_nx = dec_err ? RESP : SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (sel_ready || to_hit) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Pclk) begin
    if (!Presetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (transfer) begin
            addr_q  <= cmd_addr;
            write_q <= cmd_write;
            wdata_q <= cmd_wdata;
            strb_q  <= cmd_write ? cmd_strb : '0;
            idx_q   <= cmd_idx;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= dec_err;
            to_q    <= 1'b0;
          end
        end
        ACCESS: begin
          if (sel_ready) begin
            rdata_q <= (write_q || sel_err) ? '0 : sel_rdata;
            err_q   <= sel_err;
            to_q    <= 1'b0;
          end else if (to_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign Penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rsp_valid ? rdata_q : '0;
  assign rsp_err     = rsp_valid & err_q;
  assign rsp_timeout = rsp_valid & to_q;
  assign Paddr       = addr_q;
  assign Pwrite      = write_q;
  assign Pwdata      = wdata_q;
  assign Pstrb       = strb_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: random transfers against a
// reference model, plus a 3-slave instance for decode errors.
module tb_apb_master_ctrl;

  logic         Pclk;
  logic         Presetn;
  logic         transfer, cmd_ready, cmd_write;
  logic [31:0]  cmd_addr, cmd_wdata;
  logic [3:0]   cmd_strb;
  logic         rsp_valid, rsp_err, rsp_timeout;
  logic [31:0]  rsp_rdata, Paddr, Pwdata;
  logic [3:0]   Psel, Pstrb, Pready, Pslverr;
  logic         Penable, Pwrite;
  logic [127:0] Prdata;

  logic         transfer3, cmd_ready3, rsp_valid3, rsp_err3, rsp_to3;
  logic [31:0]  cmd_addr3, rsp_rdata3, Paddr3, Pwdata3;
  logic [2:0]   Psel3;
  logic [3:0]   Pstrb3;
  logic         Penable3, Pwrite3;
  logic [95:0]  Prdata3;

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .Pclk(Pclk), .Presetn(Presetn),
    .transfer(transfer), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .Paddr(Paddr), .Psel(Psel), .Penable(Penable),
    .Pwrite(Pwrite), .Pwdata(Pwdata), .Pstrb(Pstrb),
    .Pready(Pready), .Prdata(Prdata), .Pslverr(Pslverr)
  );

  apb_master_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .NUM_SLAVES(3), .TIMEOUT_CYCLES(16)
  ) dut3 (
    .Pclk(Pclk), .Presetn(Presetn),
    .transfer(transfer3), .cmd_ready(cmd_ready3),
    .cmd_write(1'b0), .cmd_addr(cmd_addr3),
    .cmd_wdata(32'h0), .cmd_strb(4'h0),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3),
    .rsp_err(rsp_err3), .rsp_timeout(rsp_to3),
    .Paddr(Paddr3), .Psel(Psel3), .Penable(Penable3),
    .Pwrite(Pwrite3), .Pwdata(Pwdata3), .Pstrb(Pstrb3),
    .Pready(3'b111), .Prdata(Prdata3), .Pslverr(3'b000)
  );

  initial begin
    Pclk = 0;
    forever #5 Pclk = ~Pclk;
  end

  typedef struct {
    int          rsp_cyc;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  strb, sel;
    logic        wr, err, to;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1;

  int          cur_waits = 0;
  bit          cur_stall = 0;
  bit          cur_err = 0;
  logic [31:0] cur_rdata = 0;

  always @(posedge Pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h @%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic expired(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired @%0d", nm, cyc);
  endtask

  // Slave side: unselected lanes carry noise, selected one follows cfg
  int acc = 0;
  always @(negedge Pclk) begin
    Pready  = 4'($urandom);
    Pslverr = 4'($urandom);
    for (int i = 0; i < 4; i++) Prdata[i*32 +: 32] = $urandom;
    if (Penable) begin
      for (int i = 0; i < 4; i++) begin
        if (Psel[i]) begin
          Pready[i] = !cur_stall && (acc == cur_waits);
          if (Pready[i]) begin
            Pslverr[i]          = cur_err;
            Prdata[i*32 +: 32]  = cur_rdata;
          end
        end
      end
      acc++;
    end else begin
      acc = 0;
    end
  end

  exp_t mexp;
  exp_t last;
  bit   have_last = 0;
  always @(negedge Pclk) begin
    if (Presetn && mon_en) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mexp = sb.pop_front();
          chk("rsp_latency", 64'(cyc), 64'(mexp.rsp_cyc));
          chk("rsp_rdata", rsp_rdata, mexp.rdata);
          chk("rsp_err", rsp_err, mexp.err);
          chk("rsp_timeout", rsp_timeout, mexp.to);
          chk("resp_bus_idle", {Psel, Penable, cmd_ready}, 0);
          last      = mexp;
          have_last = 1;
        end
      end else begin
        chk("rsp_zero", {rsp_err, rsp_timeout, rsp_rdata}, 0);
        if (Psel != 0) begin
          if (sb.size() == 0) begin
            chk("psel_unexpected", Psel, 0);
          end else begin
            chk("psel", Psel, sb[0].sel);
            chk("paddr", Paddr, sb[0].addr);
            chk("pwrite", Pwrite, sb[0].wr);
            chk("pwdata", Pwdata, sb[0].wdata);
            chk("pstrb", Pstrb, sb[0].strb);
          end
        end else if (have_last) begin
          chk("paddr_hold", Paddr, last.addr);
          chk("pstrb_hold", Pstrb, last.strb);
          chk("penable_idle", Penable, 0);
        end
      end
    end
  end

  task automatic do_txn(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        input int waits, input bit stall, input bit err,
                        input logic [31:0] rdata);
    exp_t e;
    int k;
    k = 0;
    while (!(cmd_ready && sb.size() == 0) && k < 50) begin
      @(negedge Pclk);
      k++;
    end
    if (k >= 50) begin
      expired("cmd_ready");
      sb.delete();
    end
    cur_waits = waits;
    cur_stall = stall;
    cur_err   = err;
    cur_rdata = rdata;
    transfer  = 1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    e.addr  = addr;
    e.wdata = wdata;
    e.wr    = wr;
    e.strb  = wr ? strb : 4'h0;
    e.sel   = 4'b0001 << addr[31:30];
    if (stall) begin
      e.err = 1;
      e.to = 1;
      e.rdata = 0;
      e.rsp_cyc = cyc + 1 + 17;
    end else begin
      e.err = err;
      e.to = 0;
      e.rdata = (wr || err) ? 32'h0 : rdata;
      e.rsp_cyc = cyc + 1 + 2 + waits;
    end
    sb.push_back(e);
    @(negedge Pclk);
    transfer  = 0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge Pclk);
      k++;
    end
    if (sb.size() != 0) begin
      expired("rsp_valid");
      sb.delete();
    end
  endtask

  task automatic run3(input logic [31:0] addr, input int exp_k,
                      input bit exp_err, input logic [31:0] exp_rd,
                      input bit dec);
    bit got;
    @(negedge Pclk);
    chk("dut3_cmd_ready", cmd_ready3, 1);
    transfer3 = 1;
    cmd_addr3 = addr;
    @(negedge Pclk);
    transfer3 = 0;
    got = 0;
    for (int n = 1; n <= 8 && !got; n++) begin
      if (n > 1) @(negedge Pclk);
      if (dec) chk("dut3_psel_quiet", Psel3, 0);
      if (rsp_valid3) begin
        got = 1;
        chk("dut3_latency", 64'(n), 64'(exp_k));
        chk("dut3_err", rsp_err3, exp_err);
        chk("dut3_timeout", rsp_to3, 0);
        chk("dut3_rdata", rsp_rdata3, exp_rd);
      end
    end
    if (!got) expired("dut3_rsp");
  endtask

  initial begin
    bit wr, st, er;
    Presetn   = 0;
    transfer  = 0;
    cmd_write = 0;
    cmd_addr  = 0;
    cmd_wdata = 0;
    cmd_strb  = 0;
    transfer3 = 0;
    cmd_addr3 = 0;
    Prdata3   = {32'h3333_2222, 32'h1111_0001, 32'hAAAA_0000};

    repeat (3) @(negedge Pclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_bus", {Psel, Penable, Pwrite, Pstrb}, 0);
    chk("rst_paddr", Paddr, 0);
    chk("rst_pwdata", Pwdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    Presetn = 1;

    do_txn(1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 32'h0);
    do_txn(0, 32'hC000_0000, 32'h5555_AAAA, 4'hF, 3, 0, 0, 32'h1234_5678);
    do_txn(0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 1, 32'hFFFF_FFFF);
    do_txn(1, 32'h8000_0020, 32'h0BAD_F00D, 4'h3, 0, 1, 0, 32'h0);
    do_txn(0, 32'h0000_0008, 32'h0, 4'h0, 1, 0, 0, 32'hCAFE_0001);
    do_txn(1, 32'h4000_0030, 32'h1111_2222, 4'h5, 2, 0, 1, 32'h0);

    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      st = ($urandom_range(0, 9) == 0);
      er = ($urandom_range(0, 3) == 0);
      do_txn(wr, $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 4)), st, er, $urandom);
    end

    // Stall a transfer in ACCESS, then pull reset under it
    while (!cmd_ready) @(negedge Pclk);
    mon_en    = 0;
    cur_stall = 1;
    transfer  = 1;
    cmd_write = 0;
    cmd_addr  = 32'h4000_0040;
    @(negedge Pclk);
    transfer = 0;
    repeat (3) @(negedge Pclk);
    chk("stall_in_access", {Psel, Penable}, {4'b0010, 1'b1});
    Presetn = 0;
    @(negedge Pclk);
    chk("rst_mid_bus", {Psel, Penable}, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    @(negedge Pclk);
    Presetn   = 1;
    cur_stall = 0;
    have_last = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge Pclk);
      chk("post_rst_rsp", rsp_valid, 0);
      chk("post_rst_ready", cmd_ready, 1);
    end
    chk("post_rst_paddr", Paddr, 0);
    mon_en = 1;
    do_txn(0, 32'h0000_0100, 32'h0, 4'h0, 0, 0, 0, 32'h7777_8888);

    run3(32'h8000_0000, 3, 0, 32'h3333_2222, 0);
    run3(32'hC000_0010, 1, 1, 32'h0, 1);
    run3(32'h4000_0000, 3, 0, 32'h1111_0001, 0);

    repeat (3) @(negedge Pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Parametrised APB4 master that converts a simple single-outstanding command/response port into APB SETUP/ACCESS transfers.
- Drives up to NUM_SLAVES peripherals through address-decoded Psel lines, with byte strobes and per-transfer wait-state handling.
- Aborts a transfer if the slave stalls too long (programmable timeout).
- Sits between the system-side request source and the APB peripheral fabric.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and Paddr
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32
- NUM_SLAVES, 4, number of Psel lines; range 2..16
- TIMEOUT_CYCLES, 16, ACCESS cycles with Pready low before abort; 0 disables the timeout

Ports:
- Pclk  in  1  clock; all logic on rising edge
- Presetn  in  1  reset, synchronous active-low
- transfer  in  1  command valid
- cmd_ready  out  1  command accepted when transfer && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write byte strobes
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  slave error, decode error or timeout
- rsp_timeout  out  1  error was a timeout
- Paddr  out  ADDR_WIDTH  APB address
- Psel  out  NUM_SLAVES  one-hot slave select
- Penable  out  1  APB enable
- Pwrite  out  1  APB direction
- Pwdata  out  DATA_WIDTH  APB write data
- Pstrb  out  DATA_WIDTH/8  APB write strobes
- Pready  in  NUM_SLAVES  per-slave ready
- Prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data, slave i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- Pslverr  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (Presetn low at a Pclk edge): state IDLE; all outputs 0 except cmd_ready, which is 1; timeout counter 0.
- Reset mid-transfer aborts immediately: Psel and Penable drop at that edge and no rsp_valid is produced.
- Slave decode: SB = clog2(NUM_SLAVES); idx = cmd_addr[ADDR_WIDTH-1 -: SB].
- If idx >= NUM_SLAVES (only possible for non-power-of-2 counts), decode error:
  - no APB cycle is issued;
  - the cycle after acceptance gives rsp_valid=1, rsp_err=1, rsp_timeout=0;
  - then IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On transfer, cmd_addr/cmd_write/cmd_wdata and idx are registered.
  - Next state is SETUP, or RESP on a decode error.
  - Pstrb is registered as cmd_strb for writes and all-zeros for reads.
- SETUP (one cycle):
  - Psel[idx]=1, Penable=0; Paddr/Pwrite/Pwdata/Pstrb driven from registers.
  - Next state ACCESS unconditionally.
- ACCESS:
  - Psel[idx]=1, Penable=1.
  - The transfer completes at the first edge where Pready[idx]=1.
  - On completion, capture rdata (Prdata slice idx if read, else 0) and err = Pslverr[idx], then go to RESP.
  - Otherwise the counter increments.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 while Pready is low: go to RESP with err=1, timeout=1, rdata=0.
  - The counter clears on entry to SETUP.
- RESP (one cycle):
  - rsp_valid=1 with the captured values; Psel=0, Penable=0; cmd_ready=0.
  - Next state IDLE.
- Minimum throughput: 4 cycles per transfer.
  - Accept at edge T; SETUP in cycle T..T+1; ACCESS T+1..T+2; rsp_valid in cycle T+2..T+3.
- Paddr, Pwrite, Pwdata and Pstrb hold their values after a transfer until the next SETUP.
- Pready, Prdata and Pslverr of unselected slaves are ignored.
- Pslverr is ignored unless Pready is high in ACCESS.
- A response with Pslverr=1 on a read reports rsp_rdata=0.
- cmd_* inputs are ignored whenever cmd_ready=0; there is no queueing.
- rsp_err/rsp_timeout/rsp_rdata are 0 whenever rsp_valid=0.

Test Plan:
- Zero-wait write:
  - Stimulus: addr 0x4000_0010 (idx 1), wdata 0xDEADBEEF, strb 0xF; slave 1 Pready high.
  - Required: Psel=4'b0010 for 2 cycles, Penable high in the 2nd; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states:
  - Stimulus: addr 0xC000_0000 (idx 3); Pready low 3 ACCESS cycles, then high with Prdata=0x1234_5678.
  - Required: Paddr stable throughout; Pstrb=0; rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error:
  - Stimulus: read idx 0; slave returns Pready=1, Pslverr=1, Prdata=0xFFFF_FFFF.
  - Required: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; slave 2 holds Pready low forever.
  - Required: exactly 16 ACCESS cycles; then Psel/Penable=0; rsp_err=1, rsp_timeout=1. A following transfer to slave 0 completes normally.
- Decode error:
  - Stimulus: NUM_SLAVES=3, idx 3.
  - Required: Psel stays 0; rsp_valid the cycle after accept with rsp_err=1.
- Reset mid-ACCESS:
  - Stimulus: Presetn low during a stalled ACCESS.
  - Required: next edge Psel=0, Penable=0, no rsp_valid; cmd_ready=1 after reset release.
